game_over_controller: RTL and testbench

GAME_OVER_CONTROLLER -- requirements
Module: game_over_controller

---
 rtl/game_over_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_game_over_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_over_controller.sv
// ---------------------------------------------------------------------------
// game_over_controller
//
// Sequences the "game over" banner: after a lose event it waits a number of
// frames, slides a 32x32 bitmap (magnified by 1<<SCALE_SHIFT) down from
// START_Y to TARGET_Y one step per frame, then blinks it in place until the
// player restarts.  For every pixel it also reports, one clock later, whether
// that pixel falls inside the visible box and which bitmap texel it maps to.
//
// Ports
//   clk             pixel clock
//   resetN          asynchronous active-low reset
//   pixelX/pixelY   current VGA column/row (11 bits)
//   startOfFrame    one-clock pulse at the start of each frame
//   lose            one-clock pulse: the game has been lost
//   restart         one-clock pulse: the player asks for a new game
//   InsideRectangle current pixel (previous clock) is inside the visible box
//   offsetX/offsetY bitmap column/row 0..31 when inside, else 0
//   GAMEOVER        high while the banner is sliding or shown
// ---------------------------------------------------------------------------
module game_over_controller #(
    parameter int unsigned SCALE_SHIFT  = 2,
    parameter int unsigned TARGET_X     = 256,
    parameter int unsigned TARGET_Y     = 176,
    parameter int unsigned START_Y      = 0,
    parameter int unsigned SLIDE_STEP   = 8,
    parameter int unsigned DELAY_FRAMES = 30,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        lose,
    input  logic        restart,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        GAMEOVER
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDelay = 2'd1;
    localparam logic [1:0] StSlide = 2'd2;
    localparam logic [1:0] StShow  = 2'd3;

    localparam int unsigned BoxSize = 32 << SCALE_SHIFT;

    localparam logic [11:0] BoxSize12 = 12'(BoxSize);
    localparam logic [11:0] TargetX12 = 12'(TARGET_X);
    localparam logic [11:0] TargetY12 = 12'(TARGET_Y);
    localparam logic [11:0] Step12    = 12'(SLIDE_STEP);
    localparam logic [10:0] StartY11  = 11'(START_Y);

    // One frame counter is shared by DELAY and SHOW, so size it for the larger.
    localparam int unsigned CntMax = (DELAY_FRAMES > BLINK_FRAMES) ? DELAY_FRAMES
                                                                   : BLINK_FRAMES;
    localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

    localparam logic [CntW-1:0] LastDelay = CntW'(DELAY_FRAMES - 1);
    localparam logic [CntW-1:0] LastBlink = CntW'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      state_q,    state_d;
    logic [10:0]     top_y_q,    top_y_d;
    logic [CntW-1:0] cnt_q,      cnt_d;
    logic            visible_q,  visible_d;
    logic            gameover_q, gameover_d;
    logic            inside_q,   inside_d;
    logic [10:0]     off_x_q,    off_x_d;
    logic [10:0]     off_y_q,    off_y_d;

    // Slide arithmetic is done one bit wider so the clamp cannot wrap.
    logic [11:0] slide_sum;
    logic [11:0] slide_next;

    always_comb begin
        slide_sum  = {1'b0, top_y_q} + Step12;
        slide_next = (slide_sum >= TargetY12) ? TargetY12 : slide_sum;
    end

    // ------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        top_y_d   = top_y_q;
        cnt_d     = cnt_q;
        visible_d = visible_q;

        if (restart) begin
            // restart dominates lose and every state
            state_d   = StIdle;
            top_y_d   = StartY11;
            cnt_d     = '0;
            visible_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (lose) begin
                        state_d = StDelay;
                        top_y_d = StartY11;
                        cnt_d   = '0;
                    end
                end

                StDelay: begin
                    if (startOfFrame) begin
                        if (cnt_q == LastDelay) begin
                            state_d = StSlide;
                            top_y_d = StartY11;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end

                StSlide: begin
                    // topY only moves on a frame boundary so the box never tears
                    if (startOfFrame) begin
                        top_y_d = slide_next[10:0];
                        if (slide_next == TargetY12) begin
                            state_d   = StShow;
                            visible_d = 1'b1;
                            cnt_d     = '0;
                        end
                    end
                end

                StShow: begin
                    if (startOfFrame) begin
                        if (cnt_q == LastBlink) begin
                            visible_d = ~visible_q;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end

                default: begin
                    state_d   = StIdle;
                    top_y_d   = StartY11;
                    cnt_d     = '0;
                    visible_d = 1'b0;
                end
            endcase
        end

        // Decoded from the next state so the flop tracks state_q exactly.
        gameover_d = (state_d == StSlide) || (state_d == StShow);
    end

    // ------------------------------------------------------------------
    // Pixel hit test
    // ------------------------------------------------------------------
    logic [11:0] dx;
    logic [11:0] dy;
    logic        in_x;
    logic        in_y;
    logic        draw_en;

    always_comb begin
        dx = {1'b0, pixelX} - TargetX12;
        dy = {1'b0, pixelY} - {1'b0, top_y_q};

        // The >= guards reject pixels left of / above the box, whose
        // difference would otherwise wrap to a large value.
        in_x = ({1'b0, pixelX} >= TargetX12) && (dx < BoxSize12);
        in_y = ({1'b0, pixelY} >= {1'b0, top_y_q}) && (dy < BoxSize12);

        // Sliding is always drawn; once parked the box follows the blink phase.
        draw_en = (state_q == StSlide) || ((state_q == StShow) && visible_q);

        inside_d = in_x && in_y && draw_en;

        if (inside_d) begin
            off_x_d = 11'(dx >> SCALE_SHIFT);
            off_y_d = 11'(dy >> SCALE_SHIFT);
        end else begin
            off_x_d = '0;
            off_y_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StIdle;
            top_y_q    <= StartY11;
            cnt_q      <= '0;
            visible_q  <= 1'b0;
            gameover_q <= 1'b0;
            inside_q   <= 1'b0;
            off_x_q    <= '0;
            off_y_q    <= '0;
        end else begin
            state_q    <= state_d;
            top_y_q    <= top_y_d;
            cnt_q      <= cnt_d;
            visible_q  <= visible_d;
            gameover_q <= gameover_d;
            inside_q   <= inside_d;
            off_x_q    <= off_x_d;
            off_y_q    <= off_y_d;
        end
    end

    assign InsideRectangle = inside_q;
    assign offsetX         = off_x_q;
    assign offsetY         = off_y_q;
    assign GAMEOVER        = gameover_q;

endmodule

// File: tb/tb_game_over_controller.sv
// ---------------------------------------------------------------------------
// tb_game_over_controller
//
// Drives game_over_controller with short synthetic frames and random pixels,
// and compares every clock against a frame-count model: the banner's whole
// life is described by "frames seen since lose", from which delay, slide
// position and blink phase follow by plain arithmetic.
// ---------------------------------------------------------------------------
module tb_game_over_controller;

    localparam int SHIFT = 2;
    localparam int TX    = 256;
    localparam int TY    = 176;
    localparam int SY    = 0;
    localparam int STEP  = 8;
    localparam int DLY   = 30;
    localparam int BLK   = 16;
    localparam int BOX   = 32 << SHIFT;
    localparam int K     = (TY - SY + STEP - 1) / STEP;  // slide frames

    logic        clk;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        lose;
    logic        restart;
    logic        InsideRectangle;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        GAMEOVER;

    game_over_controller #(
        .SCALE_SHIFT  (SHIFT),
        .TARGET_X     (TX),
        .TARGET_Y     (TY),
        .START_Y      (SY),
        .SLIDE_STEP   (STEP),
        .DELAY_FRAMES (DLY),
        .BLINK_FRAMES (BLK)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .startOfFrame    (startOfFrame),
        .lose            (lose),
        .restart         (restart),
        .InsideRectangle (InsideRectangle),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .GAMEOVER        (GAMEOVER)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: active after a lose; m_n counts frame pulses seen since then.
    bit m_active = 1'b0;
    int m_n      = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_top();
        int t;
        if (m_n < DLY) return SY;
        t = SY + (m_n - DLY) * STEP;
        return (t > TY) ? TY : t;
    endfunction

    function automatic int rand_x();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(240, 400));
        return int'($urandom_range(0, 799));
    endfunction

    function automatic int rand_y();
        if ($urandom_range(0, 1) == 0) return m_top() + int'($urandom_range(0, 140)) - 8 < 0
                                              ? 0 : m_top() + int'($urandom_range(0, 140)) - 8;
        return int'($urandom_range(0, 599));
    endfunction

    // One clock: apply inputs, predict, clock, compare.
    task automatic step(input bit sof, input bit ls, input bit rs,
                        input int px, input int py, input string tag);
        bit slide, show, vis, hit;
        int top, ex_ox, ex_oy;
        startOfFrame = sof;
        lose         = ls;
        restart      = rs;
        pixelX       = 11'(px);
        pixelY       = 11'(py);

        slide = m_active && (m_n >= DLY) && (m_n < DLY + K);
        show  = m_active && (m_n >= DLY + K);
        vis   = show && (((m_n - DLY - K) / BLK) % 2 == 0);
        top   = m_top();
        hit   = (slide || vis) && (px >= TX) && (px < TX + BOX) && (py >= top) && (py < top + BOX);
        ex_ox = hit ? (px - TX) >> SHIFT : 0;
        ex_oy = hit ? (py - top) >> SHIFT : 0;

        if (rs) begin
            m_active = 1'b0;
            m_n      = 0;
        end else if (!m_active && ls) begin
            m_active = 1'b1;
            m_n      = 0;
        end else if (m_active && sof) begin
            m_n++;
        end

        @(posedge clk);
        #1;
        check_eq({tag, ".inside"}, InsideRectangle, hit);
        check_eq({tag, ".offx"}, offsetX, ex_ox);
        check_eq({tag, ".offy"}, offsetY, ex_oy);
        check_eq({tag, ".gameover"}, GAMEOVER, (m_active && m_n >= DLY) ? 1 : 0);
    endtask

    task automatic frame(input string tag);
        int len = int'($urandom_range(6, 12));
        for (int c = 0; c < len; c++) step(c == 0, 1'b0, 1'b0, rand_x(), rand_y(), tag);
    endtask

    task automatic frame_at(input int px, input int py, input string tag);
        for (int c = 0; c < 5; c++) step(c == 0, 1'b0, 1'b0, px, py, tag);
    endtask

    initial begin
        resetN       = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        startOfFrame = 1'b0;
        lose         = 1'b0;
        restart      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.inside", InsideRectangle, 0);
        check_eq("reset.offx", offsetX, 0);
        check_eq("reset.offy", offsetY, 0);
        check_eq("reset.gameover", GAMEOVER, 0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Forty idle frames: nothing may appear.
        repeat (40) frame("idle");

        // Delay, slide and park.
        step(1'b0, 1'b1, 1'b0, 300, 200, "lose");
        repeat (DLY - 1) frame("delay");
        check_eq("delay29.gameover", GAMEOVER, 0);
        step(1'b1, 1'b0, 1'b0, 300, 200, "sof30");
        check_eq("sof30.gameover", GAMEOVER, 1);
        step(1'b0, 1'b0, 1'b0, 256, 0, "top0");
        check_eq("top0.hit", InsideRectangle, 1);
        repeat (K) frame("slide");
        step(1'b0, 1'b0, 1'b0, 256, 176, "p256_176");
        check_eq("p256_176.c", {InsideRectangle, offsetX, offsetY}, {1'b1, 11'd0, 11'd0});
        step(1'b0, 1'b0, 1'b0, 383, 303, "p383_303");
        check_eq("p383_303.c", {InsideRectangle, offsetX, offsetY}, {1'b1, 11'd31, 11'd31});
        step(1'b0, 1'b0, 1'b0, 384, 176, "p384_176");
        check_eq("p384_176.c", {InsideRectangle, offsetX, offsetY}, 0);
        step(1'b0, 1'b0, 1'b0, 255, 200, "p255_200");
        check_eq("p255_200.c", {InsideRectangle, offsetX, offsetY}, 0);
        step(1'b0, 1'b0, 1'b0, 256, 175, "p256_175");
        check_eq("p256_175.c", InsideRectangle, 0);

        // Blink: 48 frames at a fixed in-box pixel.
        for (int f = 0; f < 3 * BLK; f++) frame_at(300, 200, "blink");

        // Restart mid-slide at topY = 80, then a fresh lose starts over.
        step(1'b0, 1'b0, 1'b1, 300, 200, "restart_show");
        step(1'b0, 1'b1, 1'b0, 300, 200, "lose2");
        repeat (DLY + 10) frame("to80");
        step(1'b0, 1'b0, 1'b0, 300, 80, "at80");
        check_eq("at80.hit", InsideRectangle, 1);
        step(1'b0, 1'b0, 1'b1, 300, 100, "restart_slide");
        check_eq("restart_slide.gameover", GAMEOVER, 0);
        step(1'b0, 1'b1, 1'b0, 300, 100, "lose3");
        repeat (DLY - 1) frame("delay3");
        check_eq("delay3.gameover", GAMEOVER, 0);
        frame("slide3");
        check_eq("slide3.gameover", GAMEOVER, 1);

        // lose and restart together from idle.
        step(1'b0, 1'b0, 1'b1, 300, 200, "to_idle");
        step(1'b0, 1'b1, 1'b1, 300, 200, "both");
        repeat (DLY + 2) frame("both_after");
        check_eq("both_after.gameover", GAMEOVER, 0);

        // Asynchronous reset during SHOW.
        step(1'b0, 1'b1, 1'b0, 300, 200, "lose4");
        repeat (DLY + K) frame("to_show");
        step(1'b0, 1'b0, 1'b0, 256, 176, "show4");
        #2;
        resetN = 1'b0;
        #1;
        check_eq("async.inside", InsideRectangle, 0);
        check_eq("async.offx", offsetX, 0);
        check_eq("async.offy", offsetY, 0);
        check_eq("async.gameover", GAMEOVER, 0);
        m_active = 1'b0;
        m_n      = 0;
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) frame("post_reset");

        // Random control traffic.
        begin
            int flen = 0;
            int fpos = 0;
            for (int c = 0; c < 6000; c++) begin
                bit sof, ls, rs;
                if (fpos == 0) flen = int'($urandom_range(6, 12));
                sof  = (fpos == 0);
                fpos = (fpos + 1 == flen) ? 0 : fpos + 1;
                ls   = ($urandom_range(0, 59) == 0);
                rs   = ($urandom_range(0, 2999) == 0);
                step(sof, ls, rs, rand_x(), rand_y(), "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
